// File: rtl/alu_seq_pkg.sv
// Shared ALU opcode package: function codes, flag-register layout and flag bit positions.
package alu_seq_pkg;

  typedef enum logic [3:0] {
    FnACC = 4'd0,
    FnMem = 4'd1,
    FnADD = 4'd2,
    FnSUB = 4'd3,
    FnAND = 4'd4,
    FnOR  = 4'd5,
    FnNOT = 4'd6,
    FnLSL = 4'd7,
    FnLSR = 4'd8,
    FnADC = 4'd9
  } alu_functions_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_seq_shifter.sv
// Logical shifter for alu_seq. ALU_BARREL_SHIFT_EN selects a combinational barrel
// shifter; otherwise a working register shifts one bit per step under a down-counter.
module alu_shifter #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             dir_right_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [SHW-1:0]   amt_i,
  output logic             last_o,
  output logic [WIDTH-1:0] res_o,
  output logic             cout_o
);

`ifdef ALU_BARREL_SHIFT_EN
  // One extra bit beyond the operand catches the last bit shifted out.
  logic [WIDTH:0] ext;
  logic           unused_ctrl;

  always_comb begin
    if (dir_right_i) begin
      ext    = {a_i, 1'b0} >> amt_i;
      res_o  = ext[WIDTH:1];
      cout_o = ext[0];
    end else begin
      ext    = {1'b0, a_i} << amt_i;
      res_o  = ext[WIDTH-1:0];
      cout_o = ext[WIDTH];
    end
  end

  assign last_o      = 1'b0;
  assign unused_ctrl = ^{clk_i, rst_i, load_i, step_i};
`else
  logic [WIDTH-1:0] work_q;
  logic [SHW-1:0]   cnt_q;
  logic             right_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= amt_i;
    end else if (step_i) begin
      cnt_q <= cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      work_q  <= a_i;
      right_q <= dir_right_i;
    end else if (step_i) begin
      work_q  <= res_o;
    end
  end

  // res_o/cout_o are the value after the next step, so the final step's result is ready to latch.
  assign res_o  = right_q ? {1'b0, work_q[WIDTH-1:1]} : {work_q[WIDTH-2:0], 1'b0};
  assign cout_o = right_q ? work_q[0] : work_q[WIDTH-1];
  assign last_o = (cnt_q == SHW'(1));
`endif

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with Start/Done handshake, Z/N/C/V flag register and carry-chained add.
// Define ALU_BARREL_SHIFT_EN for single-cycle barrel shifts (Busy then stays 0).
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       Func,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FlagWe,
  output logic [WIDTH-1:0] Result,
  output logic             Busy,
  output logic             Done,
  output logic [3:0]       Flags
);

  logic [WIDTH-1:0] res_q, res_d;
  alu_flags_t       flg_q, flg_d;
  logic             done_q, done_d;

  logic [SHW-1:0]   amt;
  logic             sh_load, sh_step, sh_last, sh_c;
  logic [WIDTH-1:0] sh_res;

  logic [WIDTH-1:0] add_b;
  logic             add_cin, add_v;
  logic [WIDTH:0]   sum;

  logic [WIDTH-1:0] op_r;
  logic             op_c, op_v, op_done, op_fwe;

`ifndef ALU_BARREL_SHIFT_EN
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;
  logic [0:0] state_q, state_d;
  logic       fwe_q;
`else
  logic       unused_last;
  assign unused_last = sh_last;
`endif

  assign amt = B[SHW-1:0];

  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .clk_i      (Clock),
    .rst_i      (Reset),
    .load_i     (sh_load),
    .step_i     (sh_step),
    .dir_right_i(Func == FnLSR),
    .a_i        (A),
    .amt_i      (amt),
    .last_o     (sh_last),
    .res_o      (sh_res),
    .cout_o     (sh_c)
  );

  // SUB reuses the adder as A + ~B + 1; ADC chains the registered carry.
  always_comb begin
    add_b   = B;
    add_cin = 1'b0;
    case (Func)
      FnSUB: begin add_b = ~B; add_cin = 1'b1; end
      FnADC: add_cin = flg_q.c;
      default: ;
    endcase
  end

  assign sum   = {1'b0, A} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
  assign add_v = (A[WIDTH-1] == add_b[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);

  always_comb begin
    res_d   = res_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    sh_load = 1'b0;
    sh_step = 1'b0;
    op_r    = '0;
    op_c    = flg_q.c;
    op_v    = flg_q.v;
    op_done = 1'b0;
    op_fwe  = FlagWe;
`ifndef ALU_BARREL_SHIFT_EN
    state_d = state_q;
    if (state_q == S_SHIFT) begin
      sh_step = 1'b1;
      if (sh_last) begin
        state_d = S_IDLE;
        op_done = 1'b1;
        op_r    = sh_res;
        op_c    = sh_c;
        op_fwe  = fwe_q;
      end
    end else
`endif
    if (Start) begin
      op_done = 1'b1;
      case (Func)
        FnACC: op_r = A;
        FnMem: op_r = B;
        FnAND: op_r = A & B;
        FnOR:  op_r = A | B;
        FnNOT: op_r = ~A;
        FnADD, FnSUB, FnADC: begin
          op_r = sum[WIDTH-1:0];
          op_c = sum[WIDTH];
          op_v = add_v;
        end
        FnLSL, FnLSR: begin
          if (amt == '0) begin
            op_r = A;
          end else begin
`ifdef ALU_BARREL_SHIFT_EN
            op_r = sh_res;
            op_c = sh_c;
`else
            op_done = 1'b0;
            sh_load = 1'b1;
            state_d = S_SHIFT;
`endif
          end
        end
        default: op_fwe = 1'b0;
      endcase
    end
    if (op_done) begin
      res_d  = op_r;
      done_d = 1'b1;
      if (op_fwe) begin
        flg_d.z = (op_r == '0);
        flg_d.n = op_r[WIDTH-1];
        flg_d.c = op_c;
        flg_d.v = op_v;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      res_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
      state_q <= S_IDLE;
`endif
    end else begin
      res_q   <= res_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
`ifndef ALU_BARREL_SHIFT_EN
      state_q <= state_d;
`endif
    end
  end

`ifndef ALU_BARREL_SHIFT_EN
  // FlagWe belongs to the op accepted with Start, not to whatever is on the port at completion.
  always_ff @(posedge Clock) begin
    if (sh_load) fwe_q <= FlagWe;
  end

  assign Busy = (state_q == S_SHIFT);
`else
  assign Busy = 1'b0;
`endif

  assign Result = res_q;
  assign Done   = done_q;
  assign Flags  = flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq; expectations follow ALU_BARREL_SHIFT_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 16;

  logic         Clock = 1'b0;
  logic         Reset, Start, FlagWe;
  logic [3:0]   Func;
  logic [W-1:0] A, B, Result;
  logic         Busy, Done;
  logic [3:0]   Flags;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 Clock = ~Clock;

  alu_seq #(.WIDTH(W)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .Start (Start),
    .Func  (Func),
    .A     (A),
    .B     (B),
    .FlagWe(FlagWe),
    .Result(Result),
    .Busy  (Busy),
    .Done  (Done),
    .Flags (Flags)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_sh(input int n);
`ifdef ALU_BARREL_SHIFT_EN
    return 1;
`else
    return (n == 0) ? 1 : n + 1;
`endif
  endfunction

  // Present one op for one edge; afterwards operands are scrambled to prove they are sampled once.
  task automatic start_op(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic we);
    Start = 1'b1; Func = f; A = a; B = b; FlagWe = we;
    @(posedge Clock); #1;
    Start = 1'b0; A = 16'hDEAD; B = 16'hBEEF; FlagWe = ~we;
  endtask

  task automatic wait_done(input string tag, input int lat0, input int exp_lat);
    int lat = lat0;
    bit bad = 1'b0;
    while (Done !== 1'b1 && lat < 40) begin
      if (Busy !== 1'b1) bad = 1'b1;
      @(posedge Clock); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " busy-while-pending"}, bad, 0);
    check({tag, " busy-at-done"}, Busy, 0);
  endtask

  task automatic op(input string tag, input logic [3:0] f, input logic [W-1:0] a,
                    input logic [W-1:0] b, input logic we, input int exp_lat,
                    input logic [W-1:0] exp_res, input logic [3:0] exp_flg);
    start_op(f, a, b, we);
    wait_done(tag, 1, exp_lat);
    check({tag, " result"}, Result, exp_res);
    check({tag, " flags"}, Flags, exp_flg);
  endtask

  initial begin
    int nd;
    Reset = 1'b1; Start = 1'b0; Func = 4'd0; A = '0; B = '0; FlagWe = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset result", Result, 0);
    check("reset busy", Busy, 0);
    check("reset done", Done, 0);
    check("reset flags", Flags, 4'b0000);
    Reset = 1'b0;

    op("add_ovf", FnADD, 16'h7FFF, 16'h0001, 1'b1, 1, 16'h8000, 4'b0101);
    @(posedge Clock); #1;
    check("done one-cycle pulse", Done, 0);
    check("result holds", Result, 16'h8000);

    op("sub_eq",    FnSUB, 16'h0005, 16'h0005, 1'b1, 1, 16'h0000, 4'b1010);
    op("adc_cin1",  FnADC, 16'hFFFF, 16'h0000, 1'b1, 1, 16'h0000, 4'b1010);
    op("adc_chain", FnADC, 16'h0001, 16'h0002, 1'b1, 1, 16'h0004, 4'b0000);
    op("adc_cin0",  FnADC, 16'h0001, 16'h0002, 1'b1, 1, 16'h0003, 4'b0000);
    op("sub_borrow", FnSUB, 16'h0003, 16'h0005, 1'b1, 1, 16'hFFFE, 4'b0100);

    op("lsl4", FnLSL, 16'h8001, 16'h0004, 1'b1, exp_sh(4), 16'h0010, 4'b0000);

    op("add_wrap", FnADD, 16'hFFFF, 16'h0001, 1'b1, 1, 16'h0000, 4'b1010);
    op("lsr0", FnLSR, 16'h8421, 16'h0010, 1'b1, 1, 16'h8421, 4'b0110);

    start_op(FnLSR, 16'h00F3, 16'h0003, 1'b1);
`ifdef ALU_BARREL_SHIFT_EN
    wait_done("lsr3", 1, 1);
`else
    Start = 1'b1; Func = FnMem; B = 16'hFFFF; FlagWe = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
    wait_done("lsr3", 2, 4);
`endif
    check("lsr3 result", Result, 16'h001E);
    check("lsr3 flags", Flags, 4'b0000);
    nd = 0;
    repeat (6) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) nd++;
    end
    check("lsr3 no second done", nd, 0);
    check("lsr3 result kept", Result, 16'h001E);

    op("add_ovf2", FnADD, 16'h7FFF, 16'h0001, 1'b1, 1, 16'h8000, 4'b0101);
    start_op(FnLSL, 16'h00FF, 16'h0005, 1'b1);
    @(posedge Clock); #1;
    Reset = 1'b1;
    @(posedge Clock); #1;
    check("abort busy", Busy, 0);
    check("abort done", Done, 0);
    check("abort result", Result, 0);
    check("abort flags", Flags, 4'b0000);
    Reset = 1'b0;
    nd = 0;
    repeat (10) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) nd++;
    end
    check("abort no spurious done", nd, 0);
    check("abort busy stays low", Busy, 0);

    op("sub_eq2",  FnSUB, 16'h0005, 16'h0005, 1'b1, 1, 16'h0000, 4'b1010);
    op("and_nowe", FnAND, 16'hF0F0, 16'h0FF0, 1'b0, 1, 16'h00F0, 4'b1010);
    op("and_we",   FnAND, 16'hF0F0, 16'h0FF0, 1'b1, 1, 16'h00F0, 4'b0010);
    op("undef",    4'hF,  16'h1234, 16'h5678, 1'b1, 1, 16'h0000, 4'b0010);
    op("not",      FnNOT, 16'h00FF, 16'h0000, 1'b1, 1, 16'hFF00, 4'b0110);
    op("mem",      FnMem, 16'h1234, 16'h0000, 1'b1, 1, 16'h0000, 4'b1010);
    op("or",       FnOR,  16'h0F00, 16'h00F0, 1'b1, 1, 16'h0FF0, 4'b0010);
    op("acc",      FnACC, 16'h8000, 16'h0001, 1'b1, 1, 16'h8000, 4'b0110);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
